// File: rtl/inst_dec_pkg.sv
// ============================================================================
// Module  : inst_dec_pkg
// Brief   : RV32I opcode constants, decode-class encoding and source-use helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_dec_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        TYPE_R    = 3'd0,
        TYPE_I    = 3'd1,
        TYPE_LOAD = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6,
        TYPE_ILL  = 3'd7
    } inst_type_e;

    function automatic logic uses_rs1(input inst_type_e t);
        return (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_LOAD) ||
               (t == TYPE_S) || (t == TYPE_B);
    endfunction

    function automatic logic uses_rs2(input inst_type_e t);
        return (t == TYPE_R) || (t == TYPE_S) || (t == TYPE_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_field_imm_gen.sv
// ============================================================================
// Module  : inst_field_imm_gen
// Brief   : Combinational opcode classification, register fields and immediate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_field_imm_gen
    import inst_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output inst_type_e      type_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] w_imm32;

    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];
    assign rd_o  = instr_i[11:7];

    always_comb begin
        type_o    = TYPE_ILL;
        illegal_o = 1'b0;
        w_imm32   = '0;
        case (instr_i[6:0])
            OPC_R: type_o = TYPE_R;
            OPC_I, OPC_JALR, OPC_SYS: begin
                type_o  = TYPE_I;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_LOAD: begin
                type_o  = TYPE_LOAD;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_S: begin
                type_o  = TYPE_S;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_B: begin
                type_o  = TYPE_B;
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                type_o  = TYPE_U;
                w_imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                type_o  = TYPE_J;
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/inst_dec_stage_ctrl.sv
// ============================================================================
// Module  : inst_dec_stage_ctrl
// Brief   : RV32I decode stage: ID register, load-use bubble, flush handling.
//           INST_DEC_STALL_CNT_EN enables the saturating hazard-stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dec_stage_ctrl
    import inst_dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    output logic                   if_ready,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   id_valid,
    output logic [2:0]             id_type,
    output logic [4:0]             id_rs1,
    output logic [4:0]             id_rs2,
    output logic [4:0]             id_rd,
    output logic [XLEN-1:0]        id_imm,
    output logic                   id_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    inst_type_e      w_dec_type;
    logic [4:0]      w_dec_rs1, w_dec_rs2, w_dec_rd;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_ill;

    inst_field_imm_gen #(.XLEN(XLEN)) u_field_imm_gen (
        .instr_i   (if_instr),
        .type_o    (w_dec_type),
        .rs1_o     (w_dec_rs1),
        .rs2_o     (w_dec_rs2),
        .rd_o      (w_dec_rd),
        .imm_o     (w_dec_imm),
        .illegal_o (w_dec_ill)
    );

    logic            full_q, full_d;
    inst_type_e      type_q, type_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            ill_q, ill_d;
    logic            ex_load_vld_q, ex_load_vld_d;
    logic [4:0]      ex_load_rd_q, ex_load_rd_d;

    logic w_hazard, w_issue, w_accept;

    // A load still in EX whose result the held instruction needs forces one bubble.
    assign w_hazard = full_q && ex_load_vld_q && (ex_load_rd_q != 5'd0) &&
                      ((uses_rs1(type_q) && (rs1_q == ex_load_rd_q)) ||
                       (uses_rs2(type_q) && (rs2_q == ex_load_rd_q)));

    assign id_valid = full_q && !w_hazard;
    assign w_issue  = id_valid && ex_ready;
    assign if_ready = !flush && !w_hazard && (!full_q || ex_ready);
    assign w_accept = if_valid && if_ready;

    always_comb begin
        full_d        = full_q;
        type_d        = type_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        ill_d         = ill_q;
        ex_load_vld_d = ex_load_vld_q;
        ex_load_rd_d  = ex_load_rd_q;
        if (flush) begin
            full_d        = 1'b0;
            ex_load_vld_d = 1'b0;
        end else begin
            // A bubble moving into EX also clears the tracked load.
            if (ex_ready) begin
                ex_load_vld_d = w_issue && (type_q == TYPE_LOAD);
                ex_load_rd_d  = rd_q;
            end
            if (w_accept) begin
                full_d = 1'b1;
                type_d = w_dec_type;
                rs1_d  = w_dec_rs1;
                rs2_d  = w_dec_rs2;
                rd_d   = w_dec_rd;
                imm_d  = w_dec_imm;
                ill_d  = w_dec_ill;
            end else if (w_issue) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q        <= 1'b0;
            type_q        <= TYPE_R;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            ill_q         <= 1'b0;
            ex_load_vld_q <= 1'b0;
            ex_load_rd_q  <= '0;
        end else begin
            full_q        <= full_d;
            type_q        <= type_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            ill_q         <= ill_d;
            ex_load_vld_q <= ex_load_vld_d;
            ex_load_rd_q  <= ex_load_rd_d;
        end
    end

    assign id_type    = type_q;
    assign id_rs1     = rs1_q;
    assign id_rs2     = rs2_q;
    assign id_rd      = rd_q;
    assign id_imm     = imm_q;
    assign id_illegal = ill_q;

`ifdef INST_DEC_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (w_hazard && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
